// File: rtl/plane_setup_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : gpu_interp_pkg
// Shared FSM encoding, width helpers and saturation constant for plane setup.
// Rev    : 1.0  initial release
// ============================================================================
package gpu_interp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DIV   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exact signed width for det and the attribute numerators.
  function automatic int num_width(input int cw, input int aw);
    return aw + 2 * cw + 3;
  endfunction

  // Dividend width: |N| needs one bit less than the signed numerator, plus FRAC.
  function automatic int div_width(input int cw, input int aw, input int frac);
    return aw + 2 * cw + 2 + frac;
  endfunction

  function automatic logic [63:0] sat_max(input int ow);
    return (64'd1 << (ow - 1)) - 64'd1;
  endfunction

  localparam logic [63:0] C_SAT_MAX_OW32 = sat_max(32);

endpackage
`default_nettype wire

// File: rtl/plane_setup_seq_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_divider
// Unsigned restoring divider, one quotient bit per cycle, done pulses once.
// Rev    : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int DW = 46
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int              CNTW   = $clog2(DW + 1);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(DW - 1);

  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_quo;
  logic [DW-1:0]   r_div;
  logic [CNTW-1:0] r_cnt;
  logic            r_active;
  logic            r_done;

  logic [DW-1:0]   w_rem_in;
  logic [DW-1:0]   w_quo_in;
  logic [DW-1:0]   w_div_in;
  logic [DW:0]     w_part;
  logic [DW:0]     w_diff;
  logic            w_ge;

  // The start cycle already performs the first iteration on the fresh operands.
  always_comb begin
    w_rem_in = start ? '0 : r_rem;
    w_quo_in = start ? dividend : r_quo;
    w_div_in = start ? divisor : r_div;
    w_part   = {w_rem_in, w_quo_in[DW-1]};
    w_diff   = w_part - {1'b0, w_div_in};
    w_ge     = ~w_diff[DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start || r_active) begin
        r_rem <= w_ge ? w_diff[DW-1:0] : w_part[DW-1:0];
        r_quo <= {w_quo_in[DW-2:0], w_ge};
        r_div <= w_div_in;
        if (start) begin
          r_cnt    <= C_LAST;
          r_active <= (C_LAST != '0);
          r_done   <= (C_LAST == '0);
        end else begin
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end
        end
      end
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/plane_setup_seq.sv
`default_nettype none
// ============================================================================
// Module : plane_setup_seq
// Triangle plane-equation setup (gx, gy, c per channel) on one shared divider.
// Option : PLANE_SETUP_ROUND_EN selects round-half-away-from-zero quotients.
// Rev    : 1.0  initial release
// ============================================================================
module plane_setup_seq
  import gpu_interp_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int CW   = 12,
  parameter int AW   = 12,
  parameter int FRAC = 8,
  parameter int OW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     x0,
  input  logic [CW-1:0]     y0,
  input  logic [CW-1:0]     x1,
  input  logic [CW-1:0]     y1,
  input  logic [CW-1:0]     x2,
  input  logic [CW-1:0]     y2,
  input  logic [NCH*AW-1:0] attr0,
  input  logic [NCH*AW-1:0] attr1,
  input  logic [NCH*AW-1:0] attr2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*OW-1:0] grad_x,
  output logic [NCH*OW-1:0] grad_y,
  output logic [NCH*OW-1:0] offset,
  output logic              degenerate,
  output logic              saturated,
  output logic              busy
);

  localparam int NW  = num_width(CW, AW);
  localparam int DW  = div_width(CW, AW, FRAC);
  localparam int MW  = (DW > OW) ? DW : OW;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [MW-1:0] C_SAT = MW'(sat_max(OW));

  state_t              r_state;
  logic [CW-1:0]       r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic [NCH*AW-1:0]   r_a0, r_a1, r_a2;
  logic signed [NW-1:0] r_ngx [NCH];
  logic signed [NW-1:0] r_ngy [NCH];
  logic signed [NW-1:0] r_nc  [NCH];
  logic [NW-1:0]       r_abs_det;
  logic                r_det_neg;
  logic [CHW-1:0]      r_ch;
  logic [1:0]          r_kind;
  logic                r_start;

  logic signed [NW-1:0] w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;
  logic signed [NW-1:0] w_k0, w_k1, w_k2;
  logic signed [NW-1:0] w_det;
  logic [NW-1:0]       w_abs_det;
  logic signed [NW-1:0] w_ngx [NCH];
  logic signed [NW-1:0] w_ngy [NCH];
  logic signed [NW-1:0] w_nc  [NCH];

  logic signed [NW-1:0] w_num;
  logic [NW-2:0]       w_abs_num;
  logic [DW-1:0]       w_dividend;
  logic [DW-1:0]       w_divisor;
  logic [DW-1:0]       w_quotient;
  logic                w_div_done;
  logic [MW-1:0]       w_q_ext;
  logic                w_over;
  logic [OW-1:0]       w_mag;
  logic [OW-1:0]       w_coef;
  logic                w_last;

  // Coordinates are unsigned; widen first so every product below is exact.
  assign w_x0 = signed'(NW'(r_x0));
  assign w_y0 = signed'(NW'(r_y0));
  assign w_x1 = signed'(NW'(r_x1));
  assign w_y1 = signed'(NW'(r_y1));
  assign w_x2 = signed'(NW'(r_x2));
  assign w_y2 = signed'(NW'(r_y2));

  assign w_k0  = w_x1 * w_y2 - w_x2 * w_y1;
  assign w_k1  = w_x2 * w_y0 - w_x0 * w_y2;
  assign w_k2  = w_x0 * w_y1 - w_x1 * w_y0;
  assign w_det = w_x0 * (w_y1 - w_y2) + w_x1 * (w_y2 - w_y0) + w_x2 * (w_y0 - w_y1);
  assign w_abs_det = w_det[NW-1] ? -w_det : w_det;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [NW-1:0] w_s0, w_s1, w_s2;
    assign w_s0 = signed'(NW'(r_a0[k*AW +: AW]));
    assign w_s1 = signed'(NW'(r_a1[k*AW +: AW]));
    assign w_s2 = signed'(NW'(r_a2[k*AW +: AW]));
    assign w_ngx[k] = w_s0 * (w_y1 - w_y2) + w_s1 * (w_y2 - w_y0) + w_s2 * (w_y0 - w_y1);
    assign w_ngy[k] = w_s0 * (w_x2 - w_x1) + w_s1 * (w_x0 - w_x2) + w_s2 * (w_x1 - w_x0);
    assign w_nc[k]  = w_s0 * w_k0 + w_s1 * w_k1 + w_s2 * w_k2;
  end

  always_comb begin
    w_num = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_ch == CHW'(k)) begin
        case (r_kind)
          2'd0:    w_num = r_ngx[k];
          2'd1:    w_num = r_ngy[k];
          default: w_num = r_nc[k];
        endcase
      end
    end
    w_abs_num = (NW-1)'(w_num[NW-1] ? -w_num : w_num);
`ifdef PLANE_SETUP_ROUND_EN
    w_dividend = {w_abs_num, {FRAC{1'b0}}} + DW'(r_abs_det >> 1);
`else
    w_dividend = {w_abs_num, {FRAC{1'b0}}};
`endif
    w_divisor = DW'(r_abs_det);
  end

  // Clamp the magnitude first, then apply the sign so both limits are symmetric.
  always_comb begin
    w_q_ext = MW'(w_quotient);
    w_over  = (w_q_ext > C_SAT);
    w_mag   = w_over ? OW'(C_SAT) : OW'(w_quotient);
    w_coef  = (w_num[NW-1] ^ r_det_neg) ? -w_mag : w_mag;
    w_last  = (r_ch == CHW'(NCH - 1)) && (r_kind == 2'd2);
  end

  seq_divider #(
    .DW(DW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (r_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .quotient (w_quotient),
    .done     (w_div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      degenerate <= 1'b0;
      saturated  <= 1'b0;
      grad_x     <= '0;
      grad_y     <= '0;
      offset     <= '0;
      r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0;
      r_a0 <= '0; r_a1 <= '0; r_a2 <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_ngx[k] <= '0;
        r_ngy[k] <= '0;
        r_nc[k]  <= '0;
      end
      r_abs_det <= '0;
      r_det_neg <= 1'b0;
      r_ch      <= '0;
      r_kind    <= 2'd0;
      r_start   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x0 <= x0; r_y0 <= y0; r_x1 <= x1; r_y1 <= y1; r_x2 <= x2; r_y2 <= y2;
            r_a0 <= attr0; r_a1 <= attr1; r_a2 <= attr2;
            grad_x     <= '0;
            grad_y     <= '0;
            offset     <= '0;
            degenerate <= 1'b0;
            saturated  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          for (int k = 0; k < NCH; k++) begin
            r_ngx[k] <= w_ngx[k];
            r_ngy[k] <= w_ngy[k];
            r_nc[k]  <= w_nc[k];
          end
          r_abs_det <= w_abs_det;
          r_det_neg <= w_det[NW-1];
          r_ch      <= '0;
          r_kind    <= 2'd0;
          if (w_det == '0) begin
            degenerate <= 1'b1;
            out_valid  <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_start <= 1'b1;
            r_state <= DIV;
          end
        end
        DIV: begin
          if (w_div_done) begin
            for (int k = 0; k < NCH; k++) begin
              if (r_ch == CHW'(k)) begin
                case (r_kind)
                  2'd0:    grad_x[k*OW +: OW] <= w_coef;
                  2'd1:    grad_y[k*OW +: OW] <= w_coef;
                  default: offset[k*OW +: OW] <= w_coef;
                endcase
              end
            end
            if (w_over) saturated <= 1'b1;
            if (w_last) begin
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              if (r_kind == 2'd2) begin
                r_kind <= 2'd0;
                r_ch   <= r_ch + CHW'(1);
              end else begin
                r_kind <= r_kind + 2'd1;
              end
              r_start <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plane_setup_seq.sv
`default_nettype none
// Bench for plane_setup_seq: directed and random triangles checked against
// a plain-arithmetic plane-equation model.
module tb_plane_setup_seq;

  localparam int NCH  = 3;
  localparam int CW   = 12;
  localparam int AW   = 12;
  localparam int FRAC = 8;
  localparam int OW   = 32;
  localparam int DWM  = AW + 2 * CW + 2 + FRAC;
  localparam int LAT  = 2 + 3 * NCH * (DWM + 1);
`ifdef PLANE_SETUP_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam longint SATMAX = (longint'(1) << (OW - 1)) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]     x0, y0, x1, y1, x2, y2;
  logic [NCH*AW-1:0] attr0, attr1, attr2;
  logic [NCH*OW-1:0] grad_x, grad_y, offset;
  logic              degenerate, saturated, busy;

  int n_vec = 0;
  int n_err = 0;

  int vx[3], vy[3];
  int sa[3][NCH];
  logic [OW-1:0] exp_gx[NCH], exp_gy[NCH], exp_c[NCH];
  bit            exp_deg, exp_sat;
  logic [OW-1:0] got_gx[NCH], got_gy[NCH], got_c[NCH];
  logic          got_deg, got_sat;

  always #5 clk = ~clk;

  plane_setup_seq #(
    .NCH(NCH), .CW(CW), .AW(AW), .FRAC(FRAC), .OW(OW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .attr0(attr0), .attr1(attr1), .attr2(attr2),
    .out_valid(out_valid), .out_ready(out_ready),
    .grad_x(grad_x), .grad_y(grad_y), .offset(offset),
    .degenerate(degenerate), .saturated(saturated), .busy(busy)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plane coefficient from the numerator/determinant quotient rule.
  function automatic logic [OW-1:0] coef(input longint n, input longint d, inout bit sat);
    longint an, ad, q;
    an = (n < 0) ? -n : n;
    ad = (d < 0) ? -d : d;
    q  = ((an << FRAC) + (ROUND ? ad / 2 : longint'(0))) / ad;
    if (q > SATMAX) begin
      q   = SATMAX;
      sat = 1'b1;
    end
    if ((n < 0) != (d < 0)) q = -q;
    return OW'(q);
  endfunction

  task automatic build_expected();
    longint px[3], py[3], s0, s1, s2, det, ngx, ngy, nc;
    for (int i = 0; i < 3; i++) begin
      px[i] = longint'(vx[i]);
      py[i] = longint'(vy[i]);
    end
    det = px[0] * (py[1] - py[2]) + px[1] * (py[2] - py[0]) + px[2] * (py[0] - py[1]);
    exp_deg = (det == 0);
    exp_sat = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      s0  = longint'(sa[0][k]);
      s1  = longint'(sa[1][k]);
      s2  = longint'(sa[2][k]);
      ngx = s0 * (py[1] - py[2]) + s1 * (py[2] - py[0]) + s2 * (py[0] - py[1]);
      ngy = s0 * (px[2] - px[1]) + s1 * (px[0] - px[2]) + s2 * (px[1] - px[0]);
      nc  = s0 * (px[1] * py[2] - px[2] * py[1]) + s1 * (px[2] * py[0] - px[0] * py[2])
          + s2 * (px[0] * py[1] - px[1] * py[0]);
      if (exp_deg) begin
        exp_gx[k] = '0;
        exp_gy[k] = '0;
        exp_c[k]  = '0;
      end else begin
        exp_gx[k] = coef(ngx, det, exp_sat);
        exp_gy[k] = coef(ngy, det, exp_sat);
        exp_c[k]  = coef(nc, det, exp_sat);
      end
    end
  endtask

  task automatic drive_ports();
    x0 = CW'(vx[0]); y0 = CW'(vy[0]);
    x1 = CW'(vx[1]); y1 = CW'(vy[1]);
    x2 = CW'(vx[2]); y2 = CW'(vy[2]);
    for (int k = 0; k < NCH; k++) begin
      attr0[k*AW +: AW] = AW'(sa[0][k]);
      attr1[k*AW +: AW] = AW'(sa[1][k]);
      attr2[k*AW +: AW] = AW'(sa[2][k]);
    end
  endtask

  task automatic scramble_ports();
    x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom);
    y1 = CW'($urandom); x2 = CW'($urandom); y2 = CW'($urandom);
    attr0 = NCH*AW'({$urandom, $urandom});
    attr1 = NCH*AW'({$urandom, $urandom});
    attr2 = NCH*AW'({$urandom, $urandom});
  endtask

  task automatic check_outputs(input string name);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s gx%0d", name, k), 64'(grad_x[k*OW +: OW]), 64'(exp_gx[k]));
      check($sformatf("%s gy%0d", name, k), 64'(grad_y[k*OW +: OW]), 64'(exp_gy[k]));
      check($sformatf("%s c%0d", name, k),  64'(offset[k*OW +: OW]), 64'(exp_c[k]));
    end
    check({name, " degenerate"}, 64'(degenerate), 64'(exp_deg));
    check({name, " saturated"},  64'(saturated),  64'(exp_sat));
  endtask

  task automatic run_triangle(input string name, input int hold);
    int lat;
    build_expected();
    @(negedge clk);
    check({name, " in_ready idle"}, 64'(in_ready), 64'd1);
    drive_ports();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_ports();
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_deg ? 2 : LAT));
    check_outputs(name);
    check({name, " busy"}, 64'(busy), 64'd1);
    for (int k = 0; k < NCH; k++) begin
      got_gx[k] = grad_x[k*OW +: OW];
      got_gy[k] = grad_y[k*OW +: OW];
      got_c[k]  = offset[k*OW +: OW];
    end
    got_deg = degenerate;
    got_sat = saturated;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      scramble_ports();
      check({name, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({name, " hold in_ready"},  64'(in_ready),  64'd0);
      check({name, " hold gx0"}, 64'(grad_x[OW-1:0]), 64'(exp_gx[0]));
      check({name, " hold c2"},  64'(offset[NCH*OW-1 -: OW]), 64'(exp_c[NCH-1]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " post out_valid"}, 64'(out_valid), 64'd0);
    check({name, " post in_ready"},  64'(in_ready),  64'd1);
    check({name, " post busy"},      64'(busy),      64'd0);
  endtask

  task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
    vx[0] = ax; vy[0] = ay; vx[1] = bx; vy[1] = by; vx[2] = cx; vy[2] = cy;
  endtask

  task automatic rand_attrs();
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < NCH; k++)
        sa[v][k] = int'($urandom_range(0, (1 << AW) - 1));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    attr0 = '0; attr1 = '0; attr2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset grad_x",    64'(grad_x[63:0]), 64'd0);
    check("reset offset",    64'(offset[63:0]), 64'd0);
    check("reset flags",     64'({degenerate, saturated}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Right triangle, positive and negative numerators, long output hold.
    set_tri(0, 0, 16, 0, 0, 16);
    rand_attrs();
    sa[0][0] = 0;  sa[1][0] = 16; sa[2][0] = 0;
    sa[0][1] = 16; sa[1][1] = 0;  sa[2][1] = 0;
    run_triangle("right16", 10);
    check("right16 ch0 gx const", 64'(got_gx[0]), 64'h0000_0100);
    check("right16 ch0 gy const", 64'(got_gy[0]), 64'h0);
    check("right16 ch1 gx const", 64'(got_gx[1]), 64'hFFFF_FF00);
    check("right16 ch1 gy const", 64'(got_gy[1]), 64'hFFFF_FF00);
    check("right16 ch1 c const",  64'(got_c[1]),  64'h0000_1000);

    set_tri(0, 0, 1, 1, 2, 2);
    rand_attrs();
    run_triangle("collinear", 1);
    check("collinear deg const", 64'(got_deg), 64'd1);

    set_tri(0, 0, 3, 0, 0, 3);
    rand_attrs();
    sa[0][0] = 0; sa[1][0] = 2; sa[2][0] = 0;
    run_triangle("third", 0);
    check("third gx rounding", 64'(got_gx[0]), ROUND ? 64'd171 : 64'd170);

    set_tri(4000, 4000, 4001, 4000, 4000, 4001);
    rand_attrs();
    sa[0][0] = 4095; sa[1][0] = 0; sa[2][0] = 0;
    run_triangle("tiny", 2);
    check("tiny saturated const", 64'(got_sat), 64'd1);

    for (int t = 0; t < 12; t++) begin
      int bx, by, span;
      rand_attrs();
      if (t % 5 == 4) begin
        by = int'($urandom_range(0, 4095));
        set_tri(int'($urandom_range(0, 4095)), by, int'($urandom_range(0, 4095)), by,
                int'($urandom_range(0, 4095)), by);
      end else begin
        span = (t % 3 == 0) ? 3 : 4095;
        bx = int'($urandom_range(0, 4095 - span));
        by = int'($urandom_range(0, 4095 - span));
        set_tri(bx + int'($urandom_range(0, span)), by + int'($urandom_range(0, span)),
                bx + int'($urandom_range(0, span)), by + int'($urandom_range(0, span)),
                bx + int'($urandom_range(0, span)), by + int'($urandom_range(0, span)));
      end
      run_triangle($sformatf("rand%0d", t), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of the divide sequence.
    set_tri(10, 20, 300, 40, 50, 900);
    rand_attrs();
    @(negedge clk);
    drive_ports();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy",      64'(busy),      64'd0);
    check("midrst in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    set_tri(100, 50, 20, 700, 900, 300);
    rand_attrs();
    run_triangle("after_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
